// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and FSM state type for the shift-add multiplier.
package mult_pkg;
    localparam int A_W   = 8;
    localparam int B_W   = 5;
    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(B_W + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
endpackage

// File: rtl/seq_mult_sequencer_if.sv
// seq_mult_sequencer_if: request/result handshake between master and the multiplier.
interface seq_mult_sequencer_if;
    import mult_pkg::*;
    logic           start;
    logic           clear;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           in_ready;
    logic           busy;
    logic           out_valid;
    logic           out_ready;
    logic [P_W-1:0] product;
    modport master (output start, clear, a, b, out_ready,
                    input  in_ready, busy, out_valid, product);
    modport slave  (input  start, clear, a, b, out_ready,
                    output in_ready, busy, out_valid, product);
endinterface

// File: rtl/ld_reg.sv
// ld_reg: load-enabled register cell with asynchronous active-high reset to zero.
module ld_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (ld) q <= d;
endmodule

// File: rtl/seq_mult_dp.sv
// seq_mult_dp: multiplicand/multiplier/accumulator/counter/valid registers with
// the shift-add step logic, driven by strobes from the sequencer FSM.
module seq_mult_dp
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             ld_p,
    input  logic             clr_p,
    input  logic             shift_b,
    input  logic             inc_cnt,
    input  logic             set_v,
    input  logic             clr_v,
    input  logic [A_W-1:0]   a_in,
    input  logic [B_W-1:0]   b_in,
    output logic [P_W-1:0]   p,
    output logic [CNT_W-1:0] cnt,
    output logic             valid
);
    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;
    logic [P_W-1:0] addend;
    assign addend = b_q[0] ? P_W'(a_q) << cnt : '0;
    ld_reg #(.W(A_W)) u_a (.clk(clk), .rst(rst), .ld(ld_a), .d(a_in), .q(a_q));
    ld_reg #(.W(B_W)) u_b (.clk(clk), .rst(rst), .ld(ld_b | shift_b),
                           .d(ld_b ? b_in : b_q >> 1), .q(b_q));
    // clr_p also rewinds the step counter, both on accept and on abort
    ld_reg #(.W(P_W)) u_p (.clk(clk), .rst(rst), .ld(ld_p | clr_p),
                           .d(clr_p ? '0 : p + addend), .q(p));
    ld_reg #(.W(CNT_W)) u_cnt (.clk(clk), .rst(rst), .ld(inc_cnt | clr_p),
                               .d(clr_p ? '0 : cnt + CNT_W'(1)), .q(cnt));
    ld_reg #(.W(1)) u_v (.clk(clk), .rst(rst), .ld(set_v | clr_v),
                         .d(~clr_v), .q(valid));
endmodule

// File: rtl/seq_mult_sequencer.sv
// seq_mult_sequencer: IDLE/CALC/DONE control for a B_W-step shift-add multiplier
// with start/ready request and valid/ready result handshakes.
module seq_mult_sequencer
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    seq_mult_sequencer_if.slave  bus
);
    mult_state_t      st, nxt;
    logic             ld_a, ld_b, ld_p, clr_p, shift_b, inc_cnt, set_v, clr_v;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else st <= nxt;
    // clear overrides every other request, in any state
    always_comb begin
        nxt     = st;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_p    = 1'b0;
        clr_p   = 1'b0;
        shift_b = 1'b0;
        inc_cnt = 1'b0;
        set_v   = 1'b0;
        clr_v   = 1'b0;
        if (bus.clear) begin
            nxt   = IDLE;
            clr_p = 1'b1;
            clr_v = 1'b1;
        end else begin
            case (st)
                IDLE: if (bus.start) begin
                    nxt   = CALC;
                    ld_a  = 1'b1;
                    ld_b  = 1'b1;
                    clr_p = 1'b1;
                end
                CALC: begin
                    ld_p    = 1'b1;
                    shift_b = 1'b1;
                    inc_cnt = 1'b1;
                    if (cnt == CNT_W'(B_W - 1)) begin
                        nxt   = DONE;
                        set_v = 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    nxt   = IDLE;
                    clr_v = 1'b1;
                end
                default: nxt = IDLE;
            endcase
        end
    end
    assign bus.in_ready = st == IDLE;
    assign bus.busy     = st == CALC;
    seq_mult_dp u_dp (
        .clk(clk), .rst(rst),
        .ld_a(ld_a), .ld_b(ld_b), .ld_p(ld_p), .clr_p(clr_p),
        .shift_b(shift_b), .inc_cnt(inc_cnt), .set_v(set_v), .clr_v(clr_v),
        .a_in(bus.a), .b_in(bus.b),
        .p(bus.product), .cnt(cnt), .valid(bus.out_valid)
    );
endmodule

// File: tb/tb_seq_mult_sequencer.sv
// tb_seq_mult_sequencer: directed and random checks of the shift-add multiplier
// against plain a*b arithmetic and the documented latency/throughput figures.
module tb_seq_mult_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    seq_mult_sequencer_if bus ();
    seq_mult_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // drive one request; lat = clock edges from driving start until out_valid is seen
    task automatic run(input logic [7:0] ai, input logic [4:0] bi, output int lat);
        int w;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        bus.a     = ai;
        bus.b     = bi;
        bus.start = 1'b1;
        tick();
        lat       = 1;
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 5'($urandom);
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, last, n_acc, n_done, exp_p;
        logic acc_now;
        int q[$];
        logic [7:0] ta [3] = '{8'd255, 8'd0, 8'd255};
        logic [4:0] tb [3] = '{5'd31, 5'd31, 5'd0};
        bus.start = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_product", bus.product, 0);

        // asynchronous reset while calculating
        bus.a = 8'd255; bus.b = 5'd31; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        check("calc_busy", bus.busy, 1);
        check("calc_partial_nonzero", bus.product != 0, 1);
        #2 rst = 1'b1;
        #1;
        check("async_in_ready", bus.in_ready, 1);
        check("async_busy", bus.busy, 0);
        check("async_out_valid", bus.out_valid, 0);
        check("async_product", bus.product, 0);
        tick();
        rst = 1'b0;
        tick();

        run(8'd200, 5'd25, lat);
        check("lat_200x25", lat, 6);
        check("prod_200x25", bus.product, 5000);
        for (int i = 0; i < 3; i++) begin
            run(ta[i], tb[i], lat);
            check("lat_corner", lat, 6);
            check("prod_corner", bus.product, int'(ta[i]) * int'(tb[i]));
        end
        tick();
        check("idle_after_done", bus.in_ready, 1);

        // backpressure: product held, start ignored
        bus.out_ready = 1'b0;
        run(8'd100, 5'd9, lat);
        check("bp_lat", lat, 6);
        for (int i = 0; i < 10; i++) begin
            bus.start = 1'b1;
            bus.a = 8'($urandom);
            bus.b = 5'($urandom);
            tick();
            check("bp_valid", bus.out_valid, 1);
            check("bp_product", bus.product, 900);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("release_in_ready", bus.in_ready, 1);
        check("release_valid", bus.out_valid, 0);

        // clear on the third calculation cycle, together with start
        bus.a = 8'd9; bus.b = 5'd13; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        check("pre_clear_busy", bus.busy, 1);
        bus.clear = 1'b1; bus.start = 1'b1;
        tick();
        bus.clear = 1'b0; bus.start = 1'b0;
        check("clear_in_ready", bus.in_ready, 1);
        check("clear_busy", bus.busy, 0);
        check("clear_product", bus.product, 0);
        acc_now = 1'b0;
        for (int i = 0; i < 8; i++) begin
            acc_now = acc_now | bus.out_valid;
            tick();
        end
        check("clear_no_valid", acc_now, 0);
        run(8'd3, 5'd7, lat);
        check("after_clear_prod", bus.product, 21);
        check("after_clear_lat", lat, 6);
        tick();

        // random back-to-back requests against a scoreboard of a*b
        bus.start = 1'b1;
        bus.a = 8'($urandom);
        bus.b = 5'($urandom);
        last = -1; n_acc = 0; n_done = 0;
        for (int cyc = 0; cyc < 400 && n_done < 20; cyc++) begin
            acc_now = bus.in_ready && bus.start;
            if (acc_now) begin
                q.push_back(int'(bus.a) * int'(bus.b));
                if (last >= 0) check("b2b_spacing", cyc - last, 7);
                last = cyc;
                n_acc++;
            end
            tick();
            if (acc_now) begin
                bus.a = 8'($urandom);
                bus.b = 5'($urandom);
                if (n_acc == 20) bus.start = 1'b0;
            end
            if (bus.out_valid) begin
                exp_p = q.size() > 0 ? q.pop_front() : -1;
                check("b2b_product", bus.product, exp_p);
                n_done++;
            end
        end
        check("b2b_count", n_done, 20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
